// File: rtl/clks_alot_p.sv
// Shared types for the clock generator / edge-rate recovery pair.
package clks_alot_p;

    localparam int unsigned RATE_COUNTER_WIDTH = 16;

    // One-cycle edge pulses reported back to the generator.
    typedef struct packed {
        logic rising_edge;
        logic falling_edge;
    } recovered_events_s;

endpackage

// File: rtl/edge_rate_recovery.sv
// Edge-rate recovery: watches a synchronized external clock level, measures
// high/low phase lengths in enabled system cycles and declares lock once both
// phases repeat within tolerance for LOCK_COUNT consecutive captures.
module edge_rate_recovery #(
    parameter int unsigned RATE_WIDTH     = clks_alot_p::RATE_COUNTER_WIDTH,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned LOCK_CNT_WIDTH = 3
) (
    input  logic                              clk,
    input  logic                              async_rst,
    input  logic                              clk_en,
    input  logic                              recovery_en_i,
    input  logic                              clear_state_i,
    input  logic                              sense_i,
    input  logic [RATE_WIDTH-1:0]             tolerance_i,
    input  logic [RATE_WIDTH-1:0]             timeout_i,
    output clks_alot_p::recovered_events_s    recovered_events_o,
    output logic [RATE_WIDTH-1:0]             high_rate_o,
    output logic [RATE_WIDTH-1:0]             low_rate_o,
    output logic [RATE_WIDTH-1:0]             full_rate_o,
    output logic [RATE_WIDTH-1:0]             counter_current_o,
    output logic                              fully_locked_in_o,
    output logic                              loss_of_signal_o
);

    typedef enum logic [0:0] {
        StAcquire = 1'b0,
        StMeasure = 1'b1
    } state_e;

    localparam logic [RATE_WIDTH-1:0]     RateMax    = {RATE_WIDTH{1'b1}};
    localparam logic [RATE_WIDTH-1:0]     RateOne    = RATE_WIDTH'(1);
    localparam logic [LOCK_CNT_WIDTH-1:0] LockTarget = LOCK_CNT_WIDTH'(LOCK_COUNT);
    localparam logic [LOCK_CNT_WIDTH-1:0] LockOne    = LOCK_CNT_WIDTH'(1);

    // |a - b| as max - min, so no sign bit is required.
    function automatic logic [RATE_WIDTH-1:0] abs_diff(input logic [RATE_WIDTH-1:0] a,
                                                       input logic [RATE_WIDTH-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Match counter update: saturating count on match, restart on mismatch.
    function automatic logic [LOCK_CNT_WIDTH-1:0] bump(input logic [LOCK_CNT_WIDTH-1:0] cnt,
                                                       input logic                      hit);
        if (!hit) begin
            return '0;
        end
        return (cnt >= LockTarget) ? LockTarget : (cnt + LockOne);
    endfunction

    // Saturating sum of the two phase rates.
    function automatic logic [RATE_WIDTH-1:0] sat_add(input logic [RATE_WIDTH-1:0] a,
                                                      input logic [RATE_WIDTH-1:0] b);
        logic [RATE_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[RATE_WIDTH] ? RateMax : sum[RATE_WIDTH-1:0];
    endfunction

    // State registers.
    state_e                              state_q, state_d;
    logic                                sense_q, sense_d;
    logic [RATE_WIDTH-1:0]               cnt_q, cnt_d;
    logic [RATE_WIDTH-1:0]               high_rate_q, high_rate_d;
    logic [RATE_WIDTH-1:0]               low_rate_q, low_rate_d;
    logic [RATE_WIDTH-1:0]               full_rate_q, full_rate_d;
    logic [LOCK_CNT_WIDTH-1:0]           hi_match_q, hi_match_d;
    logic [LOCK_CNT_WIDTH-1:0]           lo_match_q, lo_match_d;
    logic                                lock_q, lock_d;
    logic                                loss_q, loss_d;
    // Set once a timeout has fired in the current phase so it reports only once.
    logic                                lost_q, lost_d;
    clks_alot_p::recovered_events_s      events_q, events_d;

    // Combinational helpers.
    logic                                active;
    logic                                rise;
    logic                                fall;
    logic                                edge_seen;
    logic [RATE_WIDTH-1:0]               cnt_inc;
    logic [RATE_WIDTH:0]                 cnt_plus;
    logic                                timeout_hit;
    logic                                hi_hit;
    logic                                lo_hit;

    // Edge detection, saturating count and match/timeout qualifiers.
    always_comb begin
        active      = clk_en & recovery_en_i;
        rise        = active & sense_i & ~sense_q;
        fall        = active & ~sense_i & sense_q;
        edge_seen   = rise | fall;
        cnt_inc     = (cnt_q == RateMax) ? cnt_q : (cnt_q + RateOne);
        // Extra bit keeps C+1 from wrapping when C is saturated.
        cnt_plus    = {1'b0, cnt_q} + {{RATE_WIDTH{1'b0}}, 1'b1};
        timeout_hit = active & ~edge_seen & ~lost_q & (timeout_i != '0) &
                      (cnt_plus >= {1'b0, timeout_i});
        hi_hit      = abs_diff(cnt_q, high_rate_q) <= tolerance_i;
        lo_hit      = abs_diff(cnt_q, low_rate_q) <= tolerance_i;
    end

    // Next-state logic: clear beats everything, then active-cycle updates.
    always_comb begin
        state_d     = state_q;
        sense_d     = sense_q;
        cnt_d       = cnt_q;
        high_rate_d = high_rate_q;
        low_rate_d  = low_rate_q;
        hi_match_d  = hi_match_q;
        lo_match_d  = lo_match_q;
        lost_d      = lost_q;
        events_d    = '0;
        loss_d      = 1'b0;

        if (clear_state_i) begin
            state_d     = StAcquire;
            // Track the live level so releasing clear does not create an edge.
            sense_d     = sense_i;
            cnt_d       = '0;
            high_rate_d = '0;
            low_rate_d  = '0;
            hi_match_d  = '0;
            lo_match_d  = '0;
            lost_d      = 1'b0;
        end else if (active) begin
            sense_d                 = sense_i;
            cnt_d                   = edge_seen ? RateOne : cnt_inc;
            events_d.rising_edge    = rise;
            events_d.falling_edge   = fall;

            if (edge_seen) begin
                lost_d = 1'b0;
                if (state_q == StAcquire) begin
                    // First edge only establishes phase alignment.
                    state_d = StMeasure;
                end else if (rise) begin
                    low_rate_d = cnt_q;
                    lo_match_d = bump(lo_match_q, lo_hit);
                end else begin
                    high_rate_d = cnt_q;
                    hi_match_d  = bump(hi_match_q, hi_hit);
                end
            end else if (timeout_hit) begin
                loss_d      = 1'b1;
                lost_d      = 1'b1;
                state_d     = StAcquire;
                high_rate_d = '0;
                low_rate_d  = '0;
                hi_match_d  = '0;
                lo_match_d  = '0;
            end
        end

        // Derived outputs follow the next-state values so they land with the rates.
        full_rate_d = sat_add(high_rate_d, low_rate_d);
        lock_d      = (state_d == StMeasure) && (hi_match_d >= LockTarget) &&
                      (lo_match_d >= LockTarget);
    end

    // All state, including the registered outputs.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q     <= StAcquire;
            sense_q     <= 1'b0;
            cnt_q       <= '0;
            high_rate_q <= '0;
            low_rate_q  <= '0;
            full_rate_q <= '0;
            hi_match_q  <= '0;
            lo_match_q  <= '0;
            lock_q      <= 1'b0;
            loss_q      <= 1'b0;
            lost_q      <= 1'b0;
            events_q    <= '0;
        end else begin
            state_q     <= state_d;
            sense_q     <= sense_d;
            cnt_q       <= cnt_d;
            high_rate_q <= high_rate_d;
            low_rate_q  <= low_rate_d;
            full_rate_q <= full_rate_d;
            hi_match_q  <= hi_match_d;
            lo_match_q  <= lo_match_d;
            lock_q      <= lock_d;
            loss_q      <= loss_d;
            lost_q      <= lost_d;
            events_q    <= events_d;
        end
    end

    // Output mapping.
    always_comb begin
        recovered_events_o = events_q;
        high_rate_o        = high_rate_q;
        low_rate_o         = low_rate_q;
        full_rate_o        = full_rate_q;
        counter_current_o  = cnt_q;
        fully_locked_in_o  = lock_q;
        loss_of_signal_o   = loss_q;
    end

endmodule
